dense_layer: RTL and testbench
==============================

Name: dense_layer

Overview:
- Fully-connected layer in signed fixed point; computes output_data[j] = bias[j] + sum_i(weights[j][i] * input_data[i]) for every output j.
- Sits directly upstream of the softmax stage: output_data is that stage's logit vector, and done can drive its start.
- Uses OUT_DIM parallel multiply-accumulate lanes and one input element per cycle; start/busy/done handshake matches the softmax stage.

Parameters:
- WIDTH, 32, bit width of every data, weight and bias word (signed two's complement).
- FIXED_POINT_INDEX, 16, number of fractional bits in all words.
- IN_DIM, 4, input vector length (>=1).
- OUT_DIM, 4, output vector length (>=1); must equal the downstream softmax DIMENSION.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a computation; sampled only in IDLE.
- input_data  input  signed [WIDTH-1:0] x IN_DIM  activation vector; latched on accepted start.
- weights  input  signed [WIDTH-1:0] x OUT_DIM x IN_DIM  weight matrix weights[j][i]; must stay stable while busy.
- bias  input  signed [WIDTH-1:0] x OUT_DIM  bias vector; must stay stable while busy.
- output_data  output  signed [WIDTH-1:0] x OUT_DIM  registered result; holds until the next done.
- done  output  1  one-cycle pulse when output_data is updated.
- busy  output  1  high while a computation is in flight.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; idx=0; accumulators=0; output_data all 0; done=0; busy=0. Reset asserted mid-operation aborts the computation and produces no done pulse.
- FSM states: IDLE, ACCUM, FINAL.
- IDLE:
  - On the edge where start=1, latch input_data.
  - Load acc[j] = sign-extended bias[j] << FIXED_POINT_INDEX.
  - Set idx=0, busy=1, go to ACCUM.
  - start=0 leaves the block in IDLE.
- ACCUM: each edge does acc[j] += input_data_q[idx] * weights[j][idx] (full 2*WIDTH-bit signed product, no shift) and idx++. After IN_DIM edges (idx reaches IN_DIM-1 and accumulates), go to FINAL.
- FINAL (one edge):
  - output_data[j] = sat(acc[j] >>> FIXED_POINT_INDEX).
  - done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency:
  - Accepting edge E; done is high in the cycle after edge E+IN_DIM+1.
  - With defaults, done follows 5 edges after acceptance.
  - busy is high after edges E through E+IN_DIM, and falls on the same edge done rises.
- Arithmetic rules:
  - Accumulator width is 2*WIDTH + $clog2(IN_DIM+1) + 1 bits, so no intermediate overflow is possible.
  - The final shift is arithmetic and truncates toward negative infinity; there is no rounding.
  - sat clamps to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1], i.e. 0x80000000 / 0x7FFFFFFF for WIDTH=32.
- start while busy (ACCUM/FINAL) is ignored; there is no queueing.
- Back-to-back operation: start high in the cycle done is high is accepted, because the state is already IDLE. Throughput is one result per IN_DIM+2 cycles.
- Changing input_data after acceptance does not affect the result.
- output_data is stable except on the FINAL edge.

Test Plan:
- Identity: weights = identity (1.0 = 0x00010000 on the diagonal), bias=0, x=[1.0,2.0,3.0,4.0] -> output_data=[0x00010000,0x00020000,0x00030000,0x00040000]. done pulses once, 5 edges after start is accepted; busy is high for exactly 5 cycles.
- Dense, biased, negative: all weights 0.5 (0x00008000), bias all 1.0, x=[1,2,3,4] -> every output 6.0 (0x00060000). Then x=[-1,-2,-3,-4] -> every output -4.0 (0xFFFC0000).
- Truncation: IN_DIM elements all 0 except x[0], weights[j][0]=0x00008000, bias=0.
  - x[0]=0x00000001 -> output 0x00000000.
  - x[0]=0xFFFFFFFF -> output 0xFFFFFFFF.
- Saturation: all x=0x7FFF0000, all weights 1.0, bias=0 -> all outputs 0x7FFFFFFF. Then weights = -1.0 -> all outputs 0x80000000.
- Handshake:
  - Pulse start again mid-ACCUM with different x -> ignored; the first result is correct and there is only one done.
  - Raise start in the done cycle with new x -> second result correct; its done arrives IN_DIM+2 cycles after the first.
  - Changing input_data after acceptance does not alter output_data.
- Reset mid-operation: assert reset at idx=2 -> output_data, done and busy are 0 immediately (asynchronous) and no done pulse appears. After release, a fresh start completes correctly.

Source files
------------

// File: rtl/dense_layer.sv
// Fully-connected layer: one input element per cycle into OUT_DIM parallel
// signed fixed-point MAC lanes, then an arithmetic shift and saturate to WIDTH.
module dense_layer #(
    parameter int WIDTH             = 32,
    parameter int FIXED_POINT_INDEX = 16,
    parameter int IN_DIM            = 4,
    parameter int OUT_DIM           = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] input_data  [IN_DIM],
    input  logic signed [WIDTH-1:0] weights     [OUT_DIM][IN_DIM],
    input  logic signed [WIDTH-1:0] bias        [OUT_DIM],
    output logic signed [WIDTH-1:0] output_data [OUT_DIM],
    output logic                    done,
    output logic                    busy
);

    localparam int ACC_W = 2*WIDTH + $clog2(IN_DIM+1) + 1;
    localparam int IDX_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINAL
    } state_t;

    state_t state;
    state_t next_state;

    logic        [IDX_W-1:0]   idx;
    logic signed [WIDTH-1:0]   x_q     [IN_DIM];
    logic signed [ACC_W-1:0]   acc     [OUT_DIM];
    logic signed [2*WIDTH-1:0] prod    [OUT_DIM];
    logic signed [ACC_W-1:0]   shifted [OUT_DIM];
    logic signed [WIDTH-1:0]   sat_val [OUT_DIM];
    logic                      last;

    assign last = (idx == IDX_W'(IN_DIM-1));
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = ACCUM;
            ACCUM:   if (last) next_state = FINAL;
            FINAL:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Full-width products; the shift back to WIDTH happens once at the end.
    always_comb begin
        for (int j = 0; j < OUT_DIM; j++) begin
            prod[j]    = (2*WIDTH)'(x_q[idx]) * (2*WIDTH)'(weights[j][idx]);
            shifted[j] = acc[j] >>> FIXED_POINT_INDEX;
            sat_val[j] = shifted[j][WIDTH-1:0];
            if (shifted[j] > SAT_MAX) begin
                sat_val[j] = {1'b0, {(WIDTH-1){1'b1}}};
            end else if (shifted[j] < SAT_MIN) begin
                sat_val[j] = {1'b1, {(WIDTH-1){1'b0}}};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx  <= '0;
            done <= 1'b0;
            for (int i = 0; i < IN_DIM; i++) begin
                x_q[i] <= '0;
            end
            for (int j = 0; j < OUT_DIM; j++) begin
                acc[j]         <= '0;
                output_data[j] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx <= '0;
                        for (int i = 0; i < IN_DIM; i++) begin
                            x_q[i] <= input_data[i];
                        end
                        for (int j = 0; j < OUT_DIM; j++) begin
                            acc[j] <= ACC_W'(bias[j]) <<< FIXED_POINT_INDEX;
                        end
                    end
                end
                ACCUM: begin
                    idx <= idx + 1'b1;
                    for (int j = 0; j < OUT_DIM; j++) begin
                        acc[j] <= acc[j] + ACC_W'(prod[j]);
                    end
                end
                FINAL: begin
                    done <= 1'b1;
                    for (int j = 0; j < OUT_DIM; j++) begin
                        output_data[j] <= sat_val[j];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer.sv
// Directed testbench for dense_layer: arithmetic, saturation, truncation,
// handshake timing and asynchronous reset abort.
module tb_dense_layer;

    localparam int W  = 32;
    localparam int NI = 4;
    localparam int NO = 4;

    logic                clk;
    logic                reset;
    logic                start;
    logic signed [W-1:0] x    [NI];
    logic signed [W-1:0] w    [NO][NI];
    logic signed [W-1:0] b    [NO];
    logic signed [W-1:0] out  [NO];
    logic                done;
    logic                busy;

    int checks;
    int errors;
    int lat;
    int busy_cnt;
    bit got;

    dense_layer #(
        .WIDTH(W),
        .FIXED_POINT_INDEX(16),
        .IN_DIM(NI),
        .OUT_DIM(NO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .input_data(x),
        .weights(w),
        .bias(b),
        .output_data(out),
        .done(done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_w(input logic [W-1:0] diag, input logic [W-1:0] off);
        for (int j = 0; j < NO; j++)
            for (int i = 0; i < NI; i++)
                w[j][i] = (i == j) ? diag : off;
    endtask

    task automatic set_b(input logic [W-1:0] v);
        for (int j = 0; j < NO; j++) b[j] = v;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        lat      = 0;
        got      = 1'b0;
        busy_cnt = busy ? 1 : 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < NI; i++) x[i] = '0;
        set_w('0, '0);
        set_b('0);
        #3;
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (out[j] !== 32'h0) begin
                errors++;
                $display("FAIL reset_out[%0d] got %h want 0", j, out[j]);
            end
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got done=%b busy=%b want 0 0", done, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_identity();
        logic [W-1:0] exp_v [NO];
        exp_v = '{32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000};
        set_w(32'h00010000, 32'h0);
        set_b(32'h0);
        x = '{32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000};
        do_start();
        wait_done();
        checks++;
        if (!got || lat != 5) begin
            errors++;
            $display("FAIL ident_latency got %0d (done=%b) want 5", lat, got);
        end
        checks++;
        if (busy_cnt != 5) begin
            errors++;
            $display("FAIL ident_busy_cycles got %0d want 5", busy_cnt);
        end
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (out[j] !== exp_v[j]) begin
                errors++;
                $display("FAIL ident_out[%0d] got %h want %h", j, out[j], exp_v[j]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL ident_done_width got %b want 0", done);
        end
    endtask

    task automatic test_dense();
        set_w(32'h00008000, 32'h00008000);
        set_b(32'h00010000);
        x = '{32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000};
        do_start();
        wait_done();
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (!got || out[j] !== 32'h00060000) begin
                errors++;
                $display("FAIL dense_pos[%0d] got %h want 00060000", j, out[j]);
            end
        end
        x = '{32'hFFFF0000, 32'hFFFE0000, 32'hFFFD0000, 32'hFFFC0000};
        do_start();
        wait_done();
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (!got || out[j] !== 32'hFFFC0000) begin
                errors++;
                $display("FAIL dense_neg[%0d] got %h want fffc0000", j, out[j]);
            end
        end
    endtask

    task automatic test_truncation();
        set_w('0, '0);
        for (int j = 0; j < NO; j++) w[j][0] = 32'h00008000;
        set_b('0);
        x = '{32'h00000001, 32'h0, 32'h0, 32'h0};
        do_start();
        wait_done();
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (!got || out[j] !== 32'h00000000) begin
                errors++;
                $display("FAIL trunc_pos[%0d] got %h want 00000000", j, out[j]);
            end
        end
        x[0] = 32'hFFFFFFFF;
        do_start();
        wait_done();
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (!got || out[j] !== 32'hFFFFFFFF) begin
                errors++;
                $display("FAIL trunc_neg[%0d] got %h want ffffffff", j, out[j]);
            end
        end
    endtask

    task automatic test_saturation();
        set_w(32'h00010000, 32'h00010000);
        set_b('0);
        for (int i = 0; i < NI; i++) x[i] = 32'h7FFF0000;
        do_start();
        wait_done();
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (!got || out[j] !== 32'h7FFFFFFF) begin
                errors++;
                $display("FAIL sat_pos[%0d] got %h want 7fffffff", j, out[j]);
            end
        end
        set_w(32'hFFFF0000, 32'hFFFF0000);
        do_start();
        wait_done();
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (!got || out[j] !== 32'h80000000) begin
                errors++;
                $display("FAIL sat_neg[%0d] got %h want 80000000", j, out[j]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        set_w(32'h00010000, 32'h0);
        set_b('0);
        x = '{32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000};
        do_start();
        dones = 0;
        @(negedge clk);
        x = '{32'h00050000, 32'h00060000, 32'h00070000, 32'h00080000};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ignore_done_count got %0d want 1", dones);
        end
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (out[j] !== W'((j + 1) * 32'h10000)) begin
                errors++;
                $display("FAIL ignore_out[%0d] got %h want %h",
                         j, out[j], (j + 1) * 32'h10000);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_w(32'h00010000, 32'h0);
        set_b('0);
        x = '{32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000};
        do_start();
        wait_done();
        checks++;
        if (!got || out[2] !== 32'h00030000) begin
            errors++;
            $display("FAIL b2b_first got %h want 00030000", out[2]);
        end
        x = '{32'hFFFF0000, 32'h00008000, 32'h00100000, 32'h0};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        checks++;
        if (!got || lat + 1 != NI + 2) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want %0d", lat + 1, NI + 2);
        end
        checks++;
        if (out[0] !== 32'hFFFF0000 || out[1] !== 32'h00008000 ||
            out[2] !== 32'h00100000 || out[3] !== 32'h0) begin
            errors++;
            $display("FAIL b2b_second got %h %h %h %h want ffff0000 00008000 00100000 0",
                     out[0], out[1], out[2], out[3]);
        end
    endtask

    task automatic test_input_change();
        set_w(32'h00010000, 32'h0);
        set_b(32'h00010000);
        x = '{32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000};
        do_start();
        for (int i = 0; i < NI; i++) x[i] = 32'h12340000;
        wait_done();
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (!got || out[j] !== 32'h00030000) begin
                errors++;
                $display("FAIL latch_out[%0d] got %h want 00030000", j, out[j]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        set_w(32'h00010000, 32'h0);
        set_b('0);
        x = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000};
        do_start();
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out[0] !== 32'h0 || out[3] !== 32'h0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async got out0=%h out3=%h done=%b busy=%b want 0",
                     out[0], out[3], done, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midreset_no_done got %0d active cycles want 0", dones);
        end
        x = '{32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000};
        do_start();
        wait_done();
        checks++;
        if (!got || lat != 5 || out[3] !== 32'h00040000) begin
            errors++;
            $display("FAIL midreset_restart got lat=%0d out3=%h want 5 00040000",
                     lat, out[3]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_identity();
        test_dense();
        test_truncation();
        test_saturation();
        test_ignore_start();
        test_back_to_back();
        test_input_change();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
